// File: rtl/pll_acq_ctrl.sv
// rtl/pll_acq_ctrl.sv - PLL acquisition/lock sequencer with gain scheduling, retry and fault
module pll_acq_ctrl #(
  parameter logic [31:0] DEFAULT_FREQ = 32'h0000_9C40,
  parameter logic [31:0] FREQ_MIN     = 32'h0000_7530,
  parameter logic [31:0] FREQ_MAX     = 32'h0000_C350,
  parameter logic [4:0]  LG_ACQ       = 5'd8,
  parameter logic [4:0]  LG_TRACK     = 5'd16,
  parameter logic [15:0] LOAD_CYCLES  = 16'd16,
  parameter logic [15:0] ACQ_QUIET    = 16'd64,
  parameter logic [15:0] LOCK_CNT     = 16'd256,
  parameter logic [15:0] UNLOCK_CNT   = 16'd32,
  parameter logic [15:0] ACQ_TIMEOUT  = 16'd4096,
  parameter logic [2:0]  MAX_RETRY    = 3'd3
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swiptAlive,
  input  logic [1:0]  error,
  input  logic [31:0] phase,
  input  logic        clr_fault,
  output logic        load_freq,
  output logic [4:0]  lgcoefficient,
  output logic [31:0] freq_out,
  output logic        locked,
  output logic        fault,
  output logic        clamped
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ACQ, S_TRACK, S_LOCKED, S_FAULT
  } state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] timer, timer_nx;
  logic [2:0]  retry_cnt, retry_nx;
  logic [2:0]  retry_inc;
  logic [15:0] quiet_target;
  logic        err_zero;
  logic        promote;
  logic        run_nx;
  logic        clamp_hit;
  logic [31:0] clamp_val;

  assign err_zero     = (error == 2'b00);
  assign quiet_target = (state == S_ACQ) ? ACQ_QUIET : LOCK_CNT;
  assign promote      = err_zero && (cnt == quiet_target - 16'd1);
  assign retry_inc    = retry_cnt + 3'd1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      timer         <= '0;
      retry_cnt     <= '0;
      load_freq     <= 1'b1;
      lgcoefficient <= LG_ACQ;
      freq_out      <= DEFAULT_FREQ;
      locked        <= 1'b0;
      fault         <= 1'b0;
      clamped       <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      timer         <= timer_nx;
      retry_cnt     <= retry_nx;
      load_freq     <= (state_nx == S_IDLE) || (state_nx == S_LOAD) || (state_nx == S_FAULT);
      lgcoefficient <= ((state_nx == S_TRACK) || (state_nx == S_LOCKED)) ? LG_TRACK : LG_ACQ;
      freq_out      <= run_nx ? clamp_val : DEFAULT_FREQ;
      locked        <= (state_nx == S_LOCKED);
      fault         <= (state_nx == S_FAULT);
      clamped       <= run_nx && clamp_hit;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    timer_nx = timer;
    retry_nx = retry_cnt;
    case (state)
      S_IDLE: begin
        cnt_nx   = '0;
        timer_nx = '0;
        if (swiptAlive) begin
          state_nx = S_LOAD;
          retry_nx = '0;
        end
      end
      S_LOAD: begin
        timer_nx = '0;
        if (cnt == LOAD_CYCLES - 16'd1) begin
          state_nx = S_ACQ;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_ACQ, S_TRACK: begin
        timer_nx = timer + 16'd1;
        // Quiet-count promotion takes priority over a coincident attempt timeout.
        if (promote) begin
          state_nx = (state == S_ACQ) ? S_TRACK : S_LOCKED;
          cnt_nx   = '0;
        end else if (timer == ACQ_TIMEOUT - 16'd1) begin
          retry_nx = retry_inc;
          cnt_nx   = '0;
          timer_nx = '0;
          state_nx = (retry_inc == MAX_RETRY) ? S_FAULT : S_LOAD;
        end else begin
          cnt_nx = err_zero ? cnt + 16'd1 : 16'd0;
        end
      end
      S_LOCKED: begin
        if (err_zero) begin
          cnt_nx = '0;
        end else if (cnt == UNLOCK_CNT - 16'd1) begin
          state_nx = S_ACQ;
          cnt_nx   = '0;
          timer_nx = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_FAULT: begin
        cnt_nx   = '0;
        timer_nx = '0;
        if (clr_fault) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // Losing the SWIPT heartbeat aborts everything except a latched fault.
    if (!swiptAlive && (state != S_FAULT)) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      timer_nx = '0;
    end
  end

  always_comb begin
    clamp_val = phase;
    clamp_hit = 1'b0;
    if (phase < FREQ_MIN) begin
      clamp_val = FREQ_MIN;
      clamp_hit = 1'b1;
    end else if (phase > FREQ_MAX) begin
      clamp_val = FREQ_MAX;
      clamp_hit = 1'b1;
    end
  end

  assign run_nx = (state_nx == S_ACQ) || (state_nx == S_TRACK) || (state_nx == S_LOCKED);

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// tb/tb_pll_acq_ctrl.sv - directed self-checking bench for pll_acq_ctrl
module tb_pll_acq_ctrl;
  logic        clk;
  logic        nrst;
  logic        swiptAlive;
  logic [1:0]  error;
  logic [1:0]  error_drv;
  logic [31:0] phase;
  logic        clr_fault;
  logic        load_freq;
  logic [4:0]  lgcoefficient;
  logic [31:0] freq_out;
  logic        locked;
  logic        fault;
  logic        clamped;
  logic        tog;
  logic        tog_en;

  int n_checks;
  int n_fail;

  pll_acq_ctrl dut (
    .clk(clk), .nrst(nrst), .swiptAlive(swiptAlive), .error(error),
    .phase(phase), .clr_fault(clr_fault), .load_freq(load_freq),
    .lgcoefficient(lgcoefficient), .freq_out(freq_out), .locked(locked),
    .fault(fault), .clamped(clamped)
  );

  assign error = tog_en ? {1'b0, tog} : error_drv;

  always #5 clk = ~clk;
  always @(negedge clk) tog = ~tog;

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    n_checks++;
    if ({load_freq, lgcoefficient, freq_out, locked, fault, clamped} !==
        {1'b1, 5'd8, 32'h0000_9C40, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got load=%b lg=%0d freq=%h lk=%b flt=%b clp=%b, expected 1 8 00009c40 0 0 0",
               load_freq, lgcoefficient, freq_out, locked, fault, clamped);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (load_freq !== 1'b1 || freq_out !== 32'h0000_9C40) begin
      n_fail++;
      $display("FAIL idle_hold: got load=%b freq=%h, expected 1 00009c40", load_freq, freq_out);
    end
  endtask

  task automatic test_acquire_lock();
    int n;
    phase      = 32'h0000_9000;
    error_drv  = 2'b00;
    swiptAlive = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (load_freq && n < 200);
    n_checks++;
    if (n !== 17) begin
      n_fail++;
      $display("FAIL load_length: got %0d cycles to load_freq low, expected 17", n);
    end
    n_checks++;
    if (lgcoefficient !== 5'd8) begin
      n_fail++;
      $display("FAIL acq_gain: got %0d, expected 8", lgcoefficient);
    end
    n = 0;
    while (lgcoefficient !== 5'd16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 64) begin
      n_fail++;
      $display("FAIL acq_quiet_length: got %0d, expected 64", n);
    end
    n = 0;
    while (!locked && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n !== 256) begin
      n_fail++;
      $display("FAIL track_lock_length: got %0d, expected 256", n);
    end
    n_checks++;
    if (freq_out !== 32'h0000_9000 || clamped !== 1'b0 || lgcoefficient !== 5'd16) begin
      n_fail++;
      $display("FAIL locked_outputs: got freq=%h clp=%b lg=%0d, expected 00009000 0 16",
               freq_out, clamped, lgcoefficient);
    end
  endtask

  task automatic test_unlock();
    error_drv = 2'b01;
    repeat (31) @(negedge clk);
    error_drv = 2'b00;
    repeat (2) @(negedge clk);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock_31_errors: got locked=%b, expected 1", locked);
    end
    error_drv = 2'b01;
    repeat (31) @(negedge clk);
    n_checks++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock_before_32: got locked=%b, expected 1", locked);
    end
    @(negedge clk);
    error_drv = 2'b00;
    n_checks++;
    if (locked !== 1'b0 || lgcoefficient !== 5'd8) begin
      n_fail++;
      $display("FAIL unlock_32_errors: got locked=%b lg=%0d, expected 0 8", locked, lgcoefficient);
    end
  endtask

  task automatic test_clamp();
    phase = 32'h0001_0000;
    #1;
    n_checks++;
    if (freq_out !== 32'h0000_9000) begin
      n_fail++;
      $display("FAIL clamp_latency: got %h before edge, expected 00009000", freq_out);
    end
    @(negedge clk);
    n_checks++;
    if (freq_out !== 32'h0000_C350 || clamped !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_high: got freq=%h clp=%b, expected 0000c350 1", freq_out, clamped);
    end
    phase = 32'h0000_0010;
    @(negedge clk);
    n_checks++;
    if (freq_out !== 32'h0000_7530 || clamped !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_low: got freq=%h clp=%b, expected 00007530 1", freq_out, clamped);
    end
    phase = 32'h0000_C350;
    @(negedge clk);
    n_checks++;
    if (freq_out !== 32'h0000_C350 || clamped !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_edge_max: got freq=%h clp=%b, expected 0000c350 0", freq_out, clamped);
    end
    phase = 32'h0000_9000;
  endtask

  task automatic test_swipt_drop();
    int n;
    n = 0;
    while (lgcoefficient !== 5'd16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (lgcoefficient !== 5'd16 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL reach_track: got lg=%0d locked=%b, expected 16 0", lgcoefficient, locked);
    end
    swiptAlive = 1'b0;
    @(negedge clk);
    n_checks++;
    if (load_freq !== 1'b1 || freq_out !== 32'h0000_9C40 || lgcoefficient !== 5'd8) begin
      n_fail++;
      $display("FAIL swipt_drop: got load=%b freq=%h lg=%0d, expected 1 00009c40 8",
               load_freq, freq_out, lgcoefficient);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (load_freq !== 1'b1 || freq_out !== 32'h0000_9C40) begin
      n_fail++;
      $display("FAIL idle_stays: got load=%b freq=%h, expected 1 00009c40", load_freq, freq_out);
    end
  endtask

  task automatic test_timeout_fault();
    int n;
    tog_en     = 1'b1;
    swiptAlive = 1'b1;
    for (int a = 1; a <= 3; a++) begin
      n = 0;
      while (load_freq && n < 100) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (!load_freq && n < 5000) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (n !== 4096) begin
        n_fail++;
        $display("FAIL timeout_length_%0d: got %0d, expected 4096", a, n);
      end
      if (a < 3) begin
        n_checks++;
        if (fault !== 1'b0) begin
          n_fail++;
          $display("FAIL early_fault_%0d: got fault=%b, expected 0", a, fault);
        end
        n = 0;
        while (load_freq && n < 100) begin
          @(negedge clk);
          n++;
        end
        n_checks++;
        if (n !== 16) begin
          n_fail++;
          $display("FAIL reload_length_%0d: got %0d, expected 16", a, n);
        end
      end else begin
        n_checks++;
        if (fault !== 1'b1 || load_freq !== 1'b1 || freq_out !== 32'h0000_9C40) begin
          n_fail++;
          $display("FAIL fault_entry: got fault=%b load=%b freq=%h, expected 1 1 00009c40",
                   fault, load_freq, freq_out);
        end
      end
    end
    tog_en     = 1'b0;
    error_drv  = 2'b00;
    swiptAlive = 1'b0;
    repeat (4) @(negedge clk);
    swiptAlive = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_sticky: got fault=%b, expected 1", fault);
    end
    swiptAlive = 1'b0;
    clr_fault  = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || load_freq !== 1'b1 || freq_out !== 32'h0000_9C40) begin
      n_fail++;
      $display("FAIL clr_fault: got fault=%b load=%b freq=%h, expected 0 1 00009c40",
               fault, load_freq, freq_out);
    end
  endtask

  task automatic test_async_reset();
    int n;
    phase      = 32'h0002_0000;
    error_drv  = 2'b00;
    swiptAlive = 1'b1;
    n = 0;
    while (!locked && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (locked !== 1'b1 || clamped !== 1'b1 || freq_out !== 32'h0000_C350) begin
      n_fail++;
      $display("FAIL relock: got locked=%b clp=%b freq=%h, expected 1 1 0000c350",
               locked, clamped, freq_out);
    end
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({load_freq, lgcoefficient, freq_out, locked, fault, clamped} !==
        {1'b1, 5'd8, 32'h0000_9C40, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got load=%b lg=%0d freq=%h lk=%b flt=%b clp=%b, expected 1 8 00009c40 0 0 0",
               load_freq, lgcoefficient, freq_out, locked, fault, clamped);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    clk        = 1'b0;
    tog        = 1'b0;
    tog_en     = 1'b0;
    nrst       = 1'b0;
    swiptAlive = 1'b0;
    error_drv  = 2'b00;
    phase      = 32'h0000_9000;
    clr_fault  = 1'b0;
    n_checks   = 0;
    n_fail     = 0;
    test_reset();
    test_acquire_lock();
    test_unlock();
    test_clamp();
    test_swipt_drop();
    test_timeout_fault();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
